// File: rtl/gb_cpu_fetch.sv
// Instruction fetch unit: reads the opcode byte at pc, follows a CB prefix to the
// second table byte, and hands the result to the decoder with a one-cycle valid pulse.
module gb_cpu_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    input  logic        inc_inhibit,
    input  logic [7:0]  mem_rdata,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic        opcode_valid,
    output logic [15:0] pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_OP = 2'd1,
        RD_CB = 2'd2
    } state_t;

    localparam logic [7:0] CB_BYTE = 8'hCB;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] pc_reg;
    logic [15:0] pc_next;
    logic [7:0]  opcode_reg;
    logic [7:0]  opcode_next;
    logic        cb_reg;
    logic        cb_next;
    logic        valid_reg;
    logic        valid_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            opcode_reg <= 8'h00;
            cb_reg     <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            opcode_reg <= opcode_next;
            cb_reg     <= cb_next;
            valid_reg  <= valid_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        opcode_next = opcode_reg;
        cb_next     = cb_reg;
        valid_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // A load in the request cycle lands before RD_OP, so the read uses the new pc.
                if (pc_load) begin
                    pc_next = pc_load_val;
                end
                if (fetch_req) begin
                    state_next = RD_OP;
                end
            end
            RD_OP: begin
                pc_next = inc_inhibit ? pc_reg : pc_reg + 16'd1;
                if (mem_rdata == CB_BYTE) begin
                    state_next = RD_CB;
                end else begin
                    opcode_next = mem_rdata;
                    cb_next     = 1'b0;
                    valid_next  = 1'b1;
                    state_next  = IDLE;
                end
            end
            RD_CB: begin
                opcode_next = mem_rdata;
                cb_next     = 1'b1;
                pc_next     = pc_reg + 16'd1;
                valid_next  = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus strobe decodes straight from state so an async reset drops it at once.
    assign mem_rd       = (state_reg == RD_OP) || (state_reg == RD_CB);
    assign mem_addr     = pc_reg;
    assign busy         = (state_reg != IDLE);
    assign pc           = pc_reg;
    assign opcode       = opcode_reg;
    assign cb_prefix    = cb_reg;
    assign opcode_valid = valid_reg;

endmodule

// File: tb/tb_gb_cpu_fetch.sv
// Randomized bench for gb_cpu_fetch: a 64 KiB memory image plus an instruction-level
// model of what one fetch returns (addresses read, latency, opcode, new pc).
module tb_gb_cpu_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        inc_inhibit;
    logic [7:0]  mem_rdata;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  opcode;
    logic        cb_prefix;
    logic        opcode_valid;
    logic [15:0] pc;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [15:0] model_pc;
    int          checks;
    int          errors;

    typedef struct packed {
        logic [7:0]  lat;
        logic [7:0]  nreads;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  op;
        logic        cb;
        logic [15:0] pc;
    } res_t;

    gb_cpu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .pc_load(pc_load),
        .pc_load_val(pc_load_val),
        .inc_inhibit(inc_inhibit),
        .mem_rdata(mem_rdata),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .opcode(opcode),
        .cb_prefix(cb_prefix),
        .opcode_valid(opcode_valid),
        .pc(pc),
        .busy(busy)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One fetch starting at p: a CB byte costs one more read and cycle; the
    // inhibit only affects the step after the first byte.
    function automatic res_t model(input logic [15:0] p, input logic inh);
        res_t e;
        logic [15:0] a;
        e = '0;
        e.nreads = 8'd1;
        e.a0 = p;
        a = inh ? p : p + 16'd1;
        if (mem[p] == 8'hCB) begin
            e.lat = 8'd3;
            e.nreads = 8'd2;
            e.a1 = a;
            e.op = mem[a];
            e.cb = 1'b1;
            e.pc = a + 16'd1;
        end else begin
            e.lat = 8'd2;
            e.op = mem[p];
            e.cb = 1'b0;
            e.pc = a;
        end
        return e;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("lat=%0d reads=%0d a0=%h a1=%h op=%h cb=%b pc=%h",
                         r.lat, r.nreads, r.a0, r.a1, r.op, r.cb, r.pc);
    endfunction

    // Drives one fetch and records what the bus and outputs did. Returns at the
    // negedge where opcode_valid is seen, so a following call with b2b=1 requests
    // in the same cycle as the pulse.
    task automatic do_fetch(input logic load, input logic [15:0] lval, input logic inh,
                            input logic spam, input logic b2b, output res_t r);
        r = '0;
        if (!b2b) @(negedge clk);
        fetch_req   = 1'b1;
        pc_load     = load;
        pc_load_val = lval;
        inc_inhibit = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (mem_rd) begin
                if (r.nreads == 8'd0) r.a0 = mem_addr;
                else r.a1 = mem_addr;
                r.nreads = r.nreads + 8'd1;
            end
            if (opcode_valid) begin
                r.lat = 8'(cyc);
                r.op  = opcode;
                r.cb  = cb_prefix;
                r.pc  = pc;
                break;
            end
            fetch_req   = spam;
            pc_load     = spam;
            pc_load_val = 16'($urandom);
            inc_inhibit = (cyc == 1) ? inh : 1'($urandom_range(0, 1));
        end
        fetch_req   = 1'b0;
        pc_load     = 1'b0;
        inc_inhibit = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd, mem_addr, opcode, cb_prefix, opcode_valid, pc, busy} !==
            {1'b0, RST_PC, 8'h00, 1'b0, 1'b0, RST_PC, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rd=%b addr=%h op=%h cb=%b v=%b pc=%h busy=%b",
                     mem_rd, mem_addr, opcode, cb_prefix, opcode_valid, pc, busy);
        end
        reset = 1'b0;
        model_pc = RST_PC;
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got v=%b busy=%b, expected 0 0", opcode_valid, busy);
        end
    endtask

    task automatic test_plain();
        res_t r, e;
        mem[16'h0000] = 8'h86;
        e = model(model_pc, 1'b0);
        do_fetch(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL plain_fetch: got %s, expected %s", fmt(r), fmt(e));
        end
        model_pc = e.pc;
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0 || opcode !== 8'h86 || pc !== 16'h0001) begin
            errors++;
            $display("FAIL plain_hold: got v=%b op=%h pc=%h, expected 0 86 0001",
                     opcode_valid, opcode, pc);
        end
    endtask

    task automatic test_cb();
        res_t r, e;
        mem[16'h0100] = 8'hCB;
        mem[16'h0101] = 8'h37;
        e = model(16'h0100, 1'b0);
        do_fetch(1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL cb_fetch: got %s, expected %s", fmt(r), fmt(e));
        end
        model_pc = e.pc;
        @(negedge clk);
        checks++;
        if (opcode_valid !== 1'b0 || busy !== 1'b0 || cb_prefix !== 1'b1 || pc !== 16'h0102) begin
            errors++;
            $display("FAIL cb_hold: got v=%b busy=%b cb=%b pc=%h, expected 0 0 1 0102",
                     opcode_valid, busy, cb_prefix, pc);
        end
    endtask

    task automatic test_jump();
        res_t r, e;
        @(negedge clk);
        pc_load = 1'b1;
        pc_load_val = 16'h1234;
        @(negedge clk);
        pc_load = 1'b0;
        checks++;
        if (pc !== 16'h1234 || mem_rd !== 1'b0 || opcode_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_only: got pc=%h rd=%b v=%b, expected 1234 0 0", pc, mem_rd, opcode_valid);
        end
        mem[16'h0038] = 8'h3E;
        e = model(16'h0038, 1'b0);
        do_fetch(1'b1, 16'h0038, 1'b0, 1'b0, 1'b1, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL jump_fetch: got %s, expected %s", fmt(r), fmt(e));
        end
        model_pc = e.pc;
    endtask

    task automatic test_halt();
        res_t r, e;
        mem[16'h0200] = 8'h76;
        e = model(16'h0200, 1'b1);
        do_fetch(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL halt_inhibit: got %s, expected %s", fmt(r), fmt(e));
        end
        e = model(e.pc, 1'b0);
        do_fetch(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL halt_reread: got %s, expected %s", fmt(r), fmt(e));
        end
        model_pc = e.pc;
    endtask

    task automatic test_wrap();
        res_t r, e;
        mem[16'hFFFF] = 8'hCB;
        mem[16'h0000] = 8'h00;
        e = model(16'hFFFF, 1'b0);
        do_fetch(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL wrap_cb: got %s, expected %s", fmt(r), fmt(e));
        end
        model_pc = e.pc;
    endtask

    task automatic test_back_to_back();
        res_t r, e;
        for (int i = 0; i < 6; i++) begin
            mem[model_pc] = (i % 2 == 1) ? 8'hCB : 8'(i + 1);
            mem[model_pc + 16'd1] = 8'($urandom);
            e = model(model_pc, 1'b0);
            do_fetch(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, r);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(r), fmt(e));
            end
            model_pc = e.pc;
        end
    endtask

    task automatic test_random();
        res_t r, e;
        logic load, inh, spam, b2b;
        logic [15:0] lval, p;
        for (int i = 0; i < 40; i++) begin
            load = ($urandom_range(0, 2) == 0);
            inh  = ($urandom_range(0, 3) == 0);
            spam = 1'($urandom_range(0, 1));
            b2b  = 1'($urandom_range(0, 1));
            lval = 16'($urandom);
            p    = load ? lval : model_pc;
            mem[p] = ($urandom_range(0, 2) == 0) ? 8'hCB : 8'($urandom);
            mem[p + 16'd1] = 8'($urandom);
            e = model(p, inh);
            do_fetch(load, lval, inh, spam, b2b, r);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random[%0d]: got %s, expected %s", i, fmt(r), fmt(e));
            end
            model_pc = e.pc;
        end
    endtask

    task automatic test_reset_mid();
        res_t r, e;
        int pulses;
        mem[16'h0310] = 8'h42;
        do_fetch(1'b1, 16'h0310, 1'b0, 1'b0, 1'b0, r);
        mem[16'h0300] = 8'hCB;
        mem[16'h0301] = 8'h11;
        @(negedge clk);
        fetch_req = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0300;
        @(negedge clk);
        fetch_req = 1'b1;
        pc_load = 1'b1;
        pc_load_val = 16'h0555;
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0301 || opcode !== 8'h42) begin
            errors++;
            $display("FAIL rdcb_before_reset: got rd=%b addr=%h op=%h, expected 1 0301 42",
                     mem_rd, mem_addr, opcode);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_rd, mem_addr, opcode, cb_prefix, opcode_valid, pc, busy} !==
            {1'b0, RST_PC, 8'h00, 1'b0, 1'b0, RST_PC, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_async: got rd=%b addr=%h op=%h cb=%b v=%b pc=%h busy=%b",
                     mem_rd, mem_addr, opcode, cb_prefix, opcode_valid, pc, busy);
        end
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (opcode_valid) pulses++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (opcode_valid || mem_rd) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: got %0d pulse/read cycles, expected 0", pulses);
        end
        model_pc = RST_PC;
        e = model(RST_PC, 1'b0);
        do_fetch(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, r);
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL fetch_after_reset: got %s, expected %s", fmt(r), fmt(e));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        fetch_req = 1'b0;
        pc_load = 1'b0;
        pc_load_val = 16'h0;
        inc_inhibit = 1'b0;
        model_pc = RST_PC;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_plain();
        test_cb();
        test_jump();
        test_halt();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_cpu_fetch.md
GB_CPU_FETCH -- requirements
Module: gb_cpu_fetch

Interface
REQ-001 SHALL provide parameter: RESET_PC, 16'h0000, program counter value loaded on reset.
REQ-002 SHALL provide port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: fetch_req  input  1  sequencer requests the next instruction fetch.
REQ-005 SHALL provide port: pc_load  input  1  load the program counter from pc_load_val (jump, call, return, interrupt vector).
REQ-006 SHALL provide port: pc_load_val  input  16  new program counter value.
REQ-007 SHALL provide port: inc_inhibit  input  1  suppress the PC increment on the next opcode-byte read (HALT-bug behaviour).
REQ-008 SHALL provide port: mem_rdata  input  8  bus read data, valid in any cycle where mem_rd=1.
REQ-009 SHALL provide port: mem_rd  output  1  bus read strobe.
REQ-010 SHALL provide port: mem_addr  output  16  bus address.
REQ-011 SHALL provide port: opcode  output  8  fetched opcode byte presented to gb_cpu_decoder.
REQ-012 SHALL provide port: cb_prefix  output  1  opcode belongs to the CB-prefixed table; presented to gb_cpu_decoder.
REQ-013 SHALL provide port: opcode_valid  output  1  one-cycle pulse: opcode/cb_prefix were updated.
REQ-014 SHALL provide port: pc  output  16  current program counter.
REQ-015 SHALL provide port: busy  output  1  fetch in progress; high in any state other than IDLE.

Function
REQ-016 SHALL implement a state machine with states IDLE, RD_OP and RD_CB.
REQ-017 In IDLE: mem_rd=0; if fetch_req=1, next state SHALL be RD_OP.
REQ-018 In IDLE: if pc_load=1, pc SHALL take pc_load_val on the next edge.
REQ-019 In IDLE with pc_load and fetch_req both 1: the load SHALL apply first; the RD_OP cycle SHALL read from the loaded value.
REQ-020 In RD_OP and RD_CB: mem_rd=1 and mem_addr=pc, both combinational from state and pc.
REQ-021 At the end of RD_OP: pc SHALL increment by 1, or hold if inc_inhibit=1 during that cycle.
REQ-022 At the end of RD_OP: if mem_rdata=8'hCB, next state SHALL be RD_CB; opcode, cb_prefix and opcode_valid SHALL be unchanged (no pulse).
REQ-023 At the end of RD_OP: if mem_rdata is not 8'hCB, opcode SHALL take mem_rdata, cb_prefix SHALL be 0, opcode_valid SHALL pulse in the next cycle, and next state SHALL be IDLE.
REQ-024 At the end of RD_CB: opcode SHALL take mem_rdata (including 8'hCB), cb_prefix SHALL be 1, and pc SHALL increment unconditionally.
REQ-025 After RD_CB: opcode_valid SHALL pulse in the next cycle, and next state SHALL be IDLE.
REQ-026 inc_inhibit SHALL be ignored in RD_CB and IDLE.
REQ-027 Latency from fetch_req to opcode_valid: unprefixed opcode SHALL take 2 cycles; CB-prefixed SHALL take 3 cycles.
REQ-028 opcode and cb_prefix SHALL hold their values between completions.
REQ-029 opcode_valid SHALL be registered and high for exactly one cycle per completed instruction.
REQ-030 While busy=1, fetch_req and pc_load SHALL be ignored.
REQ-031 A fetch_req in the same cycle as an opcode_valid pulse SHALL be accepted, because the state is then IDLE.
REQ-032 pc arithmetic SHALL be 16-bit modulo: 16'hFFFF+1 = 16'h0000.
REQ-033 The CB byte at 16'hFFFF SHALL read its operand from 16'h0000.

Reset
REQ-034 On reset assertion, asynchronously: state=IDLE, pc=RESET_PC, opcode=8'h00, cb_prefix=0, opcode_valid=0, mem_rd=0, mem_addr=RESET_PC.
REQ-035 Reset asserted mid-fetch (RD_OP or RD_CB) SHALL abort the fetch with no opcode_valid pulse; the bus read SHALL drop immediately.
REQ-036 After reset deasserts, the first fetch_req SHALL read address RESET_PC.

Verification
REQ-037 Plain fetch: reset, fetch_req=1 at pc=0, mem_rdata=8'h86 -> one cycle mem_rd=1 at mem_addr=0; then opcode=8'h86, cb_prefix=0, opcode_valid pulses once, pc=1.
REQ-038 CB fetch: pc=16'h0100, data 8'hCB then 8'h37 -> reads at 0100 then 0101; opcode=8'h37, cb_prefix=1, single pulse 3 cycles after fetch_req, pc=16'h0102.
REQ-039 Jump plus fetch: in IDLE, pc_load=1 with pc_load_val=16'h0038 and fetch_req=1 -> RD_OP reads 16'h0038; pc=16'h0039 afterwards.
REQ-040 HALT bug: inc_inhibit=1 during RD_OP at pc=16'h0200 -> pc stays 16'h0200; the next fetch re-reads 16'h0200.
REQ-041 Wrap: pc=16'hFFFF, data 8'hCB then 8'h00 -> second read at 16'h0000; pc=16'h0001; cb_prefix=1.
REQ-042 Reset mid-operation: reset asserted during RD_CB -> mem_rd=0 immediately, opcode=8'h00, no pulse, pc=RESET_PC; fetch_req pulses while busy are ignored with no extra read.
